// File: rtl/map_sram_pkg.sv
// Shared widths, port ids and read-tag type for the feature-map SRAM arbiter.
package map_sram_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 288;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/map_sram_arbiter_rd_tag_pipe.sv
// Read-tag shift register: tracks which port owns each in-flight SRAM read so the
// return can be steered back to it exactly READ_LATENCY cycles after issue.
module rd_tag_pipe
  import map_sram_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tag_valid,
  input  logic i_tag_port,
  output logic o_a_rvalid,
  output logic o_b_rvalid,
  output logic o_any_valid
);

  rd_tag_t r_pipe [READ_LATENCY];
  rd_tag_t w_tag_in;
  rd_tag_t w_tag_out;

  assign w_tag_in.valid = i_tag_valid;
  assign w_tag_in.port  = i_tag_port;
  assign w_tag_out      = r_pipe[READ_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_tag_in;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  always_comb begin
    o_any_valid = 1'b0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      o_any_valid = o_any_valid | r_pipe[i].valid;
    end
  end

  assign o_a_rvalid = w_tag_out.valid & (w_tag_out.port == PORT_A);
  assign o_b_rvalid = w_tag_out.valid & (w_tag_out.port == PORT_B);

endmodule

// File: rtl/map_sram_arbiter.sv
// Round-robin arbiter with burst lock sharing the single-port feature-map SRAM
// between the UART map loader (port A) and the LeNet engine (port B).
module map_sram_arbiter
  import map_sram_pkg::*;
#(
  parameter int unsigned ADDR_W       = map_sram_pkg::ADDR_W,
  parameter int unsigned DATA_W       = map_sram_pkg::DATA_W,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              sram_ena,
  output logic              sram_wea,
  output logic [ADDR_W-1:0] sram_addra,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_douta,
  output logic              busy
);

  logic              w_gnt;
  logic              w_lock_hold;
  logic              w_gnt_port;
  logic              w_gnt_we;
  logic              w_gnt_lock;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_wdata;
  logic              w_a_rvalid;
  logic              w_b_rvalid;
  logic              w_tag_busy;

  logic              r_ptr;
  logic              r_lock_vld;
  logic              r_lock_port;
  logic              r_ena;
  logic              r_wea;
  logic              r_port;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;

  // Lock only holds while the owner keeps both req and lock high.
  always_comb begin
    w_gnt       = a_req | b_req;
    w_lock_hold = r_lock_vld & ((r_lock_port == PORT_A) ? (a_req & a_lock) : (b_req & b_lock));
    if (w_lock_hold) begin
      w_gnt_port = r_lock_port;
    end else if (a_req & b_req) begin
      w_gnt_port = r_ptr;
    end else begin
      w_gnt_port = b_req ? PORT_B : PORT_A;
    end
  end

  assign w_gnt_we    = (w_gnt_port == PORT_B) ? b_we    : a_we;
  assign w_gnt_lock  = (w_gnt_port == PORT_B) ? b_lock  : a_lock;
  assign w_gnt_addr  = (w_gnt_port == PORT_B) ? b_addr  : a_addr;
  assign w_gnt_wdata = (w_gnt_port == PORT_B) ? b_wdata : a_wdata;

  assign a_gnt = w_gnt & (w_gnt_port == PORT_A);
  assign b_gnt = w_gnt & (w_gnt_port == PORT_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= PORT_A;
      r_lock_vld  <= 1'b0;
      r_lock_port <= PORT_A;
      r_ena       <= 1'b0;
      r_wea       <= 1'b0;
      r_port      <= PORT_A;
      r_addr      <= '0;
      r_din       <= '0;
    end else begin
      r_ena       <= w_gnt;
      r_wea       <= w_gnt & w_gnt_we;
      r_port      <= w_gnt_port;
      r_lock_vld  <= w_gnt & w_gnt_lock;
      r_lock_port <= w_gnt_port;
      if (w_gnt) begin
        r_ptr  <= ~w_gnt_port;
        r_addr <= w_gnt_addr;
        r_din  <= w_gnt_wdata;
      end
    end
  end

  rd_tag_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_tag_valid(r_ena & ~r_wea),
    .i_tag_port (r_port),
    .o_a_rvalid (w_a_rvalid),
    .o_b_rvalid (w_b_rvalid),
    .o_any_valid(w_tag_busy)
  );

  assign sram_ena   = r_ena;
  assign sram_wea   = r_wea;
  assign sram_addra = r_addr;
  assign sram_din   = r_din;
  assign busy       = r_ena | w_tag_busy;

  assign a_rvalid = w_a_rvalid;
  assign b_rvalid = w_b_rvalid;
  assign a_rdata  = w_a_rvalid ? sram_douta : '0;
  assign b_rdata  = w_b_rvalid ? sram_douta : '0;

endmodule

// File: doc/map_sram_arbiter.md
Name: map_sram_arbiter

Overview:
Shares the single-port feature-map SRAM (9-bit address, 288-bit word) between two requesters. Port A is the UART map loader (write-mostly). Port B is the LeNet engine (read/write). The block does round-robin arbitration with an optional burst lock, registers the winning access onto the SRAM port, and routes each read return to the requester that issued it. It sits between the top-level controller and the SRAM array, replacing the state-based mux.

Parameters:
ADDR_W, 9, SRAM address width
DATA_W, 288, SRAM word width (6*6*8)
READ_LATENCY, 1, cycles from registered SRAM ena to valid douta; legal values 1..3

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
a_req  input  1  port A access request; held until granted
a_we  input  1  port A write (1) / read (0)
a_lock  input  1  port A burst lock; keeps priority while a_req stays high
a_addr  input  ADDR_W  port A address
a_wdata  input  DATA_W  port A write data
a_gnt  output  1  port A request accepted this cycle
a_rvalid  output  1  port A read data valid
a_rdata  output  DATA_W  port A read data
b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
sram_ena  output  1  SRAM enable
sram_wea  output  1  SRAM write enable
sram_addra  output  ADDR_W  SRAM address
sram_din  output  DATA_W  SRAM write data
sram_douta  input  DATA_W  SRAM read data
busy  output  1  access issued or read in flight

Behaviour:
- Reset values:
  - All outputs are 0.
  - Priority pointer = A.
  - Lock owner = none.
  - Read-tag pipeline is cleared.
- Arbitration is combinational in cycle N:
  - a_gnt / b_gnt assert in the same cycle the request is sampled.
  - At most one grant per cycle.
  - The requester sees the grant and may change req/addr/wdata in N+1.
- Priority, highest first:
  1. Lock owner, if its req is still high.
  2. Requester selected by the pointer.
  3. The other requester.
- After any grant, the pointer moves to the non-granted port (strict alternation under contention).
- Lock:
  - Taken when the granted port has lock=1 in the grant cycle.
  - Released in the first cycle the owner's req=0 or lock=0. The other port may be granted in that same cycle.
- Issue stage (registered):
  - In N+1: sram_ena=1, and sram_wea/addra/din take the granted port's we/addr/wdata.
  - If there was no grant in N: sram_ena=0, sram_wea=0, addra/din hold their last value.
- Read return:
  - Reads carry a 2-bit tag (valid, port) through a READ_LATENCY-deep shift register.
  - rvalid for that port asserts exactly in cycle N+1+READ_LATENCY.
  - rdata = sram_douta while that port's rvalid=1; otherwise 0.
  - Writes produce no rvalid.
- Back-to-back reads from alternating ports pipeline fully (one per cycle). Returns are in issue order.
- busy = sram_ena OR any valid tag in the pipeline.
- Simultaneous a_req and b_req with no lock: the pointer decides. On the first cycle after reset, A wins.
- A req with no competitor is granted immediately, regardless of the pointer.
- A rising or falling lock with req=0 has no effect.
- Reset asserted mid-operation:
  - All outputs and state clear asynchronously.
  - In-flight reads are dropped with no rvalid.
  - The SRAM sees ena=0 immediately.
- Address and data widths pass through unmodified. The block does no range checking (address 288..511 is passed through).

Decomposition:
- Shared package (map_sram_pkg):
  - ADDR_W and DATA_W constants.
  - Port-id encoding (PORT_A=0, PORT_B=1).
  - Read-tag struct (valid, port).
- One sub-module, rd_tag_pipe: a parameterised READ_LATENCY shift register of tags with async reset. It emits per-port rvalid.
- Arbiter, lock and issue registers stay in the top module.

Test Plan:
- Reset, then a_req=1, a_we=1, addr=5, wdata=0xAA..: a_gnt=1 in the same cycle; next cycle sram_ena=1, wea=1, addra=5; no rvalid.
- a_req and b_req held high together, both reads, addrs 1 and 2, READ_LATENCY=1: grants alternate A,B,A,B starting with A; a_rvalid and b_rvalid alternate with rdata=douta, 2 cycles after each grant.
- b_lock=1 with b_req held for 4 cycles while a_req=1: b_gnt for 4 consecutive cycles; a_gnt in the cycle b_req drops.
- READ_LATENCY=3 rerun: a read granted at cycle 10 gives a_rvalid only at cycle 14; busy stays high for cycles 11..14.
- rst pulsed one cycle after a read grant: sram_ena=0 immediately, no rvalid afterwards, and the first post-reset contention goes to A.
- Write to B (addr=143) followed by a read from A (addr=143), READ_LATENCY=1, SRAM model attached: a_rdata equals the written data and b_rvalid never asserts.
